// File: rtl/clkdiv_rate_ctrl_pkg.sv
// Shared types and constants for the divider rate controller.
package clkdiv_rate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_APPLY     = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam logic [31:0] N_MIN = 32'd2;

endpackage

// File: rtl/clkdiv_rate_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves to the loser on every grant.
module rr_arb2
  import clkdiv_rate_ctrl_pkg::*;
(
  input  logic       refclk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_t ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = (ptr == REQ_A) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) ptr <= REQ_A;
    else if (advance) ptr <= grant[0] ? REQ_B : REQ_A;
  end

endmodule

// File: rtl/clkdiv_rate_ctrl.sv
// Arbitrates two rate-change requesters and loads the divider ratio on a
// falling edge of the divider output, or after a timeout if no edge appears.
module clkdiv_rate_ctrl #(
  parameter logic [31:0] N_RESET = 32'd50_000_000,
  parameter logic [31:0] N_MIN   = clkdiv_rate_ctrl_pkg::N_MIN
) (
  input  logic                          refclk,
  input  logic                          resetn,
  input  logic                          req_a,
  input  logic [31:0]                   n_a,
  input  logic                          req_b,
  input  logic [31:0]                   n_b,
  output logic                          ack_a,
  output logic                          ack_b,
  output logic                          nack_a,
  output logic                          nack_b,
  input  logic                          div_outclk,
  output logic [31:0]                   div_n,
  output logic                          busy,
  output clkdiv_rate_ctrl_pkg::state_t  dbg_state
);

  import clkdiv_rate_ctrl_pkg::*;

  // Handshake: req_x is a level held until the one-cycle ack_x/nack_x pulse;
  // n_x must be stable while req_x is high. The pulse appears the cycle after
  // RESP, and requests are not arbitrated while any pulse is visible.

  state_t      state;
  req_id_t     owner;
  logic [31:0] pend_n;
  logic [32:0] tmo_cnt;
  logic        outclk_q;
  logic        resp_nack;

  logic [1:0]  arb_req;
  logic [1:0]  grant;
  logic        arb_go;
  logic        resp_vis;
  req_id_t     win_id;
  logic [31:0] win_n;
  logic        fall;
  logic [32:0] tmo_next;
  logic        tmo_hit;

  assign resp_vis = ack_a | ack_b | nack_a | nack_b;
  assign arb_req  = (state == ST_IDLE && !resp_vis) ? {req_b, req_a} : 2'b00;

  rr_arb2 u_arb (
    .refclk  (refclk),
    .resetn  (resetn),
    .req     (arb_req),
    .advance (arb_go),
    .grant   (grant)
  );

  assign arb_go   = |grant;
  assign win_id   = grant[1] ? REQ_B : REQ_A;
  assign win_n    = grant[1] ? n_b : n_a;
  assign fall     = outclk_q & ~div_outclk;
  // 33-bit compare so div_n = 32'hFFFF_FFFF still times out instead of wrapping.
  assign tmo_next = tmo_cnt + 33'd1;
  assign tmo_hit  = (tmo_next == ({1'b0, div_n} + 33'd1));
  assign dbg_state = state;

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      owner     <= REQ_A;
      pend_n    <= '0;
      tmo_cnt   <= '0;
      outclk_q  <= 1'b0;
      resp_nack <= 1'b0;
      div_n     <= N_RESET;
      busy      <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      nack_a    <= 1'b0;
      nack_b    <= 1'b0;
    end else begin
      outclk_q <= div_outclk;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      nack_a   <= 1'b0;
      nack_b   <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= arb_go;
          if (arb_go) begin
            pend_n <= win_n;
            owner  <= win_id;
            if (win_n < N_MIN) begin
              resp_nack <= 1'b1;
              state     <= ST_RESP;
            end else if (win_n == div_n) begin
              resp_nack <= 1'b0;
              state     <= ST_RESP;
            end else begin
              resp_nack <= 1'b0;
              tmo_cnt   <= '0;
              state     <= ST_WAIT_EDGE;
            end
          end
        end
        ST_WAIT_EDGE: begin
          busy    <= 1'b1;
          tmo_cnt <= tmo_next;
          if (fall || tmo_hit) state <= ST_APPLY;
        end
        ST_APPLY: begin
          busy  <= 1'b1;
          div_n <= pend_n;
          state <= ST_RESP;
        end
        ST_RESP: begin
          busy   <= 1'b0;
          ack_a  <= !resp_nack && (owner == REQ_A);
          ack_b  <= !resp_nack && (owner == REQ_B);
          nack_a <=  resp_nack && (owner == REQ_A);
          nack_b <=  resp_nack && (owner == REQ_B);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_rate_ctrl.sv
// Directed bench for clkdiv_rate_ctrl with a response scoreboard.
module tb_clkdiv_rate_ctrl;
  import clkdiv_rate_ctrl_pkg::*;

  localparam logic [1:0] RC_ACK_A  = 2'd0;
  localparam logic [1:0] RC_ACK_B  = 2'd1;
  localparam logic [1:0] RC_NACK_A = 2'd2;
  localparam logic [1:0] RC_NACK_B = 2'd3;

  // ---------------- clock / reset ----------------
  logic refclk = 1'b0;
  logic resetn = 1'b0;
  always #5 refclk = ~refclk;

  logic        req_a = 1'b0, req_b = 1'b0, div_outclk = 1'b1;
  logic [31:0] n_a = '0, n_b = '0;
  logic        ack_a, ack_b, nack_a, nack_b, busy;
  logic [31:0] div_n;
  state_t      dbg_state;

  logic        z_req = 1'b0;
  logic [31:0] z_n = '0;
  logic        d0_ack_a, d0_ack_b, d0_nack_a, d0_nack_b, d0_busy;
  logic [31:0] d0_div_n;
  state_t      d0_state;

  clkdiv_rate_ctrl #(.N_RESET(32'd8)) dut (
    .refclk(refclk), .resetn(resetn),
    .req_a(req_a), .n_a(n_a), .req_b(req_b), .n_b(n_b),
    .ack_a(ack_a), .ack_b(ack_b), .nack_a(nack_a), .nack_b(nack_b),
    .div_outclk(div_outclk), .div_n(div_n), .busy(busy), .dbg_state(dbg_state)
  );

  clkdiv_rate_ctrl dut0 (
    .refclk(refclk), .resetn(resetn),
    .req_a(z_req), .n_a(z_n), .req_b(z_req), .n_b(z_n),
    .ack_a(d0_ack_a), .ack_b(d0_ack_b), .nack_a(d0_nack_a), .nack_b(d0_nack_b),
    .div_outclk(z_req), .div_n(d0_div_n), .busy(d0_busy), .dbg_state(d0_state)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] code, input logic [31:0] dn);
    exp_q.push_back({code, dn});
  endtask

  // Monitor: every response pulse is popped and compared with {code, div_n}.
  always @(negedge refclk) begin
    logic [3:0]  resp;
    logic [1:0]  code;
    logic [33:0] exp;
    resp = {nack_b, nack_a, ack_b, ack_a};
    if (resetn && resp != 4'b0) begin
      code = resp[3] ? RC_NACK_B : resp[2] ? RC_NACK_A : resp[1] ? RC_ACK_B : RC_ACK_A;
      if ($countones(resp) != 1) begin
        check("resp_onehot", $countones(resp), 1);
      end else if (exp_q.size() == 0) begin
        check("resp_unexpected", {2'b0, code, div_n}, 64'hFFFF_FFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        check("resp_code", code, exp[33:32]);
        check("resp_div_n", div_n, exp[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge refclk);
    resetn = 1'b0;
    @(negedge refclk);
    resetn = 1'b1;
  endtask

  task automatic run_req(input logic id, input logic [31:0] n, input int exp_lat,
                         input bit hold_after, input string name);
    int   lat;
    logic seen;
    @(negedge refclk);
    if (id) begin req_b = 1'b1; n_b = n; end
    else    begin req_a = 1'b1; n_a = n; end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge refclk);
      lat++;
      seen = id ? (ack_b | nack_b) : (ack_a | nack_a);
    end
    if (hold_after) @(negedge refclk);
    if (id) req_b = 1'b0;
    else    req_a = 1'b0;
    check(name, seen ? lat : -1, exp_lat);
    @(negedge refclk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int div_cyc, ack_cyc, ack_cnt, ta, tb_;

    repeat (3) @(negedge refclk);
    resetn = 1'b1;

    check("rst_div_n", div_n, 8);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_resp", {ack_a, ack_b, nack_a, nack_b}, 0);

    // Default instance idles at 50 MHz ratio.
    for (int i = 0; i < 100; i++) begin
      @(negedge refclk);
      check("idle_default", {d0_busy, d0_div_n}, {1'b0, 32'd50_000_000});
    end

    // Edge-synchronous load: falling edge injected mid-wait.
    push_exp(RC_ACK_A, 32'd20);
    @(negedge refclk);
    req_a = 1'b1; n_a = 32'd20;
    div_cyc = -1; ack_cyc = -1; ack_cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge refclk);
      if (c == 3) div_outclk = 1'b0;
      if (div_n == 32'd20 && div_cyc < 0) div_cyc = c;
      if (ack_a) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = c;
        req_a = 1'b0;
      end
    end
    check("edge_div_cycle", div_cyc, 5);
    check("edge_ack_cycle", ack_cyc, 6);
    check("edge_ack_count", ack_cnt, 1);

    // Invalid ratio: nack, ratio untouched.
    push_exp(RC_NACK_B, 32'd20);
    run_req(1'b1, 32'd1, 2, 1'b0, "nack_b_lat");
    check("nack_div_n", div_n, 20);

    // Same ratio: immediate ack; request held one extra cycle is ignored.
    push_exp(RC_ACK_A, 32'd20);
    run_req(1'b0, 32'd20, 2, 1'b1, "same_ack_lat");
    repeat (3) @(negedge refclk);

    // Forced load with div_outclk stuck low: 9 wait cycles at ratio 8.
    do_reset();
    push_exp(RC_ACK_A, 32'd16);
    run_req(1'b0, 32'd16, 12, 1'b0, "forced_lat");
    check("forced_div_n", div_n, 16);
    check("forced_busy", busy, 0);

    // Reset during WAIT_EDGE discards the request.
    @(negedge refclk);
    req_a = 1'b1; n_a = 32'd30;
    repeat (3) @(negedge refclk);
    check("wait_busy", busy, 1);
    check("wait_state", dbg_state, ST_WAIT_EDGE);
    resetn = 1'b0;
    req_a  = 1'b0;
    @(negedge refclk);
    check("midrst_div_n", div_n, 8);
    check("midrst_busy", busy, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge refclk);
    resetn = 1'b1;
    repeat (10) @(negedge refclk);
    push_exp(RC_ACK_A, 32'd9);
    run_req(1'b0, 32'd9, 12, 1'b0, "post_rst_lat");

    // Simultaneous requests after reset: A first, then B.
    do_reset();
    push_exp(RC_ACK_A, 32'd10);
    push_exp(RC_ACK_B, 32'd12);
    @(negedge refclk);
    req_a = 1'b1; n_a = 32'd10;
    req_b = 1'b1; n_b = 32'd12;
    ta = -1; tb_ = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge refclk);
      if (ack_a && ta < 0)  begin ta = c;  req_a = 1'b0; end
      if (ack_b && tb_ < 0) begin tb_ = c; req_b = 1'b0; end
    end
    req_a = 1'b0; req_b = 1'b0;
    check("rr_a_lat", ta, 12);
    check("rr_b_lat", tb_, 27);
    check("rr_final_div_n", div_n, 12);

    repeat (3) @(negedge refclk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
